// File: rtl/except_unit_pkg.sv
// Shared types and constants for the commit-stage exception controller.
package except_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT
  } except_state_e;

  localparam logic [11:0] EXC_OFS_REFILL  = 12'h000;
  localparam logic [11:0] EXC_OFS_GENERAL = 12'h180;
  localparam logic [11:0] EXC_OFS_IRQ     = 12'h200;
  localparam logic [31:0] EXC_BEV_BASE    = 32'hbfc00200;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_TLBL = 5'd2;
  localparam logic [4:0] EXCCODE_TLBS = 5'd3;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  typedef struct packed {
    logic        valid;
    logic        eret;
    logic [4:0]  exc_code;
    logic [31:0] extra;
    logic [31:0] pc;
    logic        delayslot;
    logic        tlb_refill;
  } exception_t;

  typedef struct packed {
    exception_t exception;
  } pipe_ex_t;

  typedef struct packed {
    logic bev;
    logic ie;
    logic exl;
    logic erl;
  } status_t;

  typedef struct packed {
    logic iv;
  } cause_t;

  typedef struct packed {
    status_t     status;
    cause_t      cause;
    logic [31:0] epc;
    logic [31:0] error_epc;
    logic [31:0] ebase;
  } cp0_regs_t;

  typedef struct packed {
    logic        valid;
    logic        eret;
    logic [4:0]  exc_code;
    logic [31:0] extra;
    logic [31:0] pc;
    logic        delayslot;
  } except_req_t;

  function automatic logic is_tlb_code(input logic [4:0] code);
    return (code == EXCCODE_TLBL) || (code == EXCCODE_TLBS);
  endfunction

endpackage

// File: rtl/except_vec_calc.sv
// Combinational exception vector / return address selection.
// Optional TLB refill vector enabled by EXCEPT_TLB_REFILL_EN.
module except_vec_calc
  import except_unit_pkg::*;
(
  input  logic        eret,
  input  logic [4:0]  exc_code,
  input  cp0_regs_t   cp0_regs,
  input  logic        tlb_refill,
  output logic [31:0] vector
);

  logic [11:0] offset;
  logic        unused_bits;

  always_comb begin
    offset = EXC_OFS_GENERAL;
    if ((exc_code == EXCCODE_INT) && cp0_regs.cause.iv && !cp0_regs.status.exl)
      offset = EXC_OFS_IRQ;
`ifdef EXCEPT_TLB_REFILL_EN
    else if (tlb_refill && is_tlb_code(exc_code) && !cp0_regs.status.exl)
      offset = EXC_OFS_REFILL;
`endif

    if (eret)
      vector = cp0_regs.status.erl ? cp0_regs.error_epc : cp0_regs.epc;
    else if (cp0_regs.status.bev)
      vector = EXC_BEV_BASE + {20'd0, offset};
    else
      vector = {cp0_regs.ebase[31:12], offset};
  end

`ifdef EXCEPT_TLB_REFILL_EN
  assign unused_bits = ^cp0_regs.ebase[11:0];
`else
  assign unused_bits = ^{cp0_regs.ebase[11:0], tlb_refill};
`endif

endmodule

// File: rtl/except_unit.sv
// Commit-end exception/interrupt controller: pick, report to CP0, flush, redirect fetch.
// Optional TLB refill vector enabled by EXCEPT_TLB_REFILL_EN (see except_vec_calc).
module except_unit
  import except_unit_pkg::*;
#(
  parameter int unsigned N_ISSUE         = 2,
  parameter int unsigned N_IRQ           = 8,
  parameter int unsigned IRQ_SYNC_STAGES = 2,
  parameter int unsigned FLUSH_CYCLES    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  pipe_ex_t [N_ISSUE-1:0]   pipe_ex,
  input  logic [N_ISSUE-1:0]       lane_valid,
  input  cp0_regs_t                cp0_regs,
  input  logic [N_IRQ-1:0]         interrupt_req,
  input  logic                     redirect_ready,
  output except_req_t              except_req,
  output logic                     flush,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic                     busy
);

  if (FLUSH_CYCLES < 1) begin : g_flush_cycles_chk
    $error("except_unit: FLUSH_CYCLES must be >= 1");
  end
  if (IRQ_SYNC_STAGES < 1) begin : g_sync_stages_chk
    $error("except_unit: IRQ_SYNC_STAGES must be >= 1");
  end

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  except_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_IRQ-1:0] irq_sync_q [IRQ_SYNC_STAGES];
  logic [N_IRQ-1:0] irq_sync;
  logic             irq_take;

  exception_t  sel_ex;
  logic        sel_found;
  logic [31:0] irq_pc;
  logic        irq_pc_found;
  except_req_t cand;
  logic        cand_tlb;
  logic        trigger;
  logic [31:0] vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < IRQ_SYNC_STAGES; i++) irq_sync_q[i] <= '0;
    end else begin
      irq_sync_q[0] <= interrupt_req;
      for (int unsigned i = 1; i < IRQ_SYNC_STAGES; i++) irq_sync_q[i] <= irq_sync_q[i-1];
    end
  end

  assign irq_sync = irq_sync_q[IRQ_SYNC_STAGES-1];
  assign irq_take = cp0_regs.status.ie & ~cp0_regs.status.exl & ~cp0_regs.status.erl
                  & (|irq_sync) & (|lane_valid);

  // Oldest lane wins for exceptions; the interrupt reports the oldest live lane's pc.
  always_comb begin
    sel_ex       = '0;
    sel_found    = 1'b0;
    irq_pc       = '0;
    irq_pc_found = 1'b0;
    for (int unsigned i = 0; i < N_ISSUE; i++) begin
      if (!sel_found && (pipe_ex[i].exception.valid || pipe_ex[i].exception.eret)) begin
        sel_found = 1'b1;
        sel_ex    = pipe_ex[i].exception;
      end
      if (!irq_pc_found && lane_valid[i]) begin
        irq_pc_found = 1'b1;
        irq_pc       = pipe_ex[i].exception.pc;
      end
    end
  end

  always_comb begin
    cand     = '0;
    cand_tlb = 1'b0;
    if (irq_take) begin
      cand.valid    = 1'b1;
      cand.exc_code = EXCCODE_INT;
      cand.pc       = irq_pc;
    end else if (sel_found) begin
      cand.valid     = 1'b1;
      cand.eret      = sel_ex.eret & ~sel_ex.valid;
      cand.exc_code  = sel_ex.exc_code;
      cand.extra     = sel_ex.extra;
      cand.pc        = sel_ex.pc;
      cand.delayslot = sel_ex.delayslot;
      cand_tlb       = sel_ex.tlb_refill;
    end
  end

  assign trigger = (state_q == IDLE) && cand.valid;

  except_vec_calc u_vec_calc (
    .eret       (cand.eret),
    .exc_code   (cand.exc_code),
    .cp0_regs   (cp0_regs),
    .tlb_refill (cand_tlb),
    .vector     (vec)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = REDIRECT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      REDIRECT: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      except_req  <= '0;
      redirect_pc <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      except_req.valid <= 1'b0;
      if (trigger) begin
        except_req  <= cand;
        redirect_pc <= vec;
      end
    end
  end

  always_comb begin
    flush          = (state_q == FLUSH);
    redirect_valid = (state_q == REDIRECT);
    busy           = (state_q != IDLE);
  end

endmodule

// File: tb/tb_except_unit.sv
// Scoreboard bench for except_unit: expected requests queued at stimulus, checked at the CP0 pulse.
module tb_except_unit;
  import except_unit_pkg::*;

  localparam int unsigned N_ISSUE = 2;
  localparam int unsigned N_IRQ   = 8;

`ifdef EXCEPT_TLB_REFILL_EN
  localparam logic [31:0] TLB_VEC = 32'h80000000;
`else
  localparam logic [31:0] TLB_VEC = 32'h80000180;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  pipe_ex_t [N_ISSUE-1:0] pipe_ex;
  logic [N_ISSUE-1:0]     lane_valid;
  cp0_regs_t              cp0_regs;
  logic [N_IRQ-1:0]       interrupt_req;
  logic                   redirect_ready;
  except_req_t            except_req;
  logic                   flush;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] pc;
    logic        eret;
    logic [31:0] vec;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] exp_vec;
  logic        exp_vec_ok = 1'b0;

  except_unit #(
    .N_ISSUE         (N_ISSUE),
    .N_IRQ           (N_IRQ),
    .IRQ_SYNC_STAGES (2),
    .FLUSH_CYCLES    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pipe_ex        (pipe_ex),
    .lane_valid     (lane_valid),
    .cp0_regs       (cp0_regs),
    .interrupt_req  (interrupt_req),
    .redirect_ready (redirect_ready),
    .except_req     (except_req),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input logic [4:0] code, input logic [31:0] pc,
                            input logic eret, input logic [31:0] vec);
    sb.push_back('{code, pc, eret, vec});
  endtask

  task automatic set_lane(input int lane, input logic exc, input logic eret,
                          input logic [4:0] code, input logic [31:0] pc, input logic tlb);
    pipe_ex[lane].exception.valid      = exc;
    pipe_ex[lane].exception.eret       = eret;
    pipe_ex[lane].exception.exc_code   = code;
    pipe_ex[lane].exception.pc         = pc;
    pipe_ex[lane].exception.tlb_refill = tlb;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) tick();
    chk(tag, 32'(busy), 32'd0);
  endtask

  // CP0 side: every request pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      exp_vec_ok = 1'b0;
    end else begin
      if (except_req.valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_req", 32'(except_req.valid), 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("req_code", 32'(except_req.exc_code), 32'(cur.code));
          chk("req_pc", except_req.pc, cur.pc);
          chk("req_eret", 32'(except_req.eret), 32'(cur.eret));
          exp_vec    = cur.vec;
          exp_vec_ok = 1'b1;
        end
      end
      if (redirect_valid) begin
        if (exp_vec_ok) chk("redirect_pc", redirect_pc, exp_vec);
        else            chk("redirect_orphan", 32'(redirect_valid), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    pipe_ex        = '0;
    lane_valid     = '0;
    cp0_regs       = '0;
    cp0_regs.ebase = 32'h80000000;
    cp0_regs.epc   = 32'h80001000;
    interrupt_req  = '0;
    redirect_ready = 1'b1;
    tick();
    tick();
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(except_req.valid), 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    rst = 1'b0;
    tick();

    // 1: lane1 overflow, flush window and redirect timing
    lane_valid = 2'b11;
    set_lane(1, 1'b1, 1'b0, EXCCODE_OV, 32'h80000104, 1'b0);
    expect_req(EXCCODE_OV, 32'h80000104, 1'b0, 32'h80000180);
    tick();
    pipe_ex = '0;
    chk("t1_req_T1", 32'(except_req.valid), 32'd1);
    chk("t1_flush_T1", 32'(flush), 32'd1);
    tick();
    chk("t1_req_T2", 32'(except_req.valid), 32'd0);
    chk("t1_flush_T2", 32'(flush), 32'd1);
    tick();
    chk("t1_flush_T3", 32'(flush), 32'd0);
    chk("t1_rv_T3", 32'(redirect_valid), 32'd1);
    tick();
    chk("t1_busy_T4", 32'(busy), 32'd0);

    // 2: both lanes excepting, fetch stalls the redirect
    redirect_ready = 1'b0;
    set_lane(0, 1'b1, 1'b0, EXCCODE_SYS, 32'h80000200, 1'b0);
    set_lane(1, 1'b1, 1'b0, EXCCODE_OV, 32'h80000204, 1'b0);
    expect_req(EXCCODE_SYS, 32'h80000200, 1'b0, 32'h80000180);
    tick();
    pipe_ex = '0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2_rv_hold", 32'(redirect_valid), 32'd1);
      tick();
    end
    chk("t2_rv_last", 32'(redirect_valid), 32'd1);
    redirect_ready = 1'b1;
    tick();
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_rv_drop", 32'(redirect_valid), 32'd0);

    // 3/5: irq pending with no live lane must not trigger, then INT beats lane exception
    cp0_regs.status.ie  = 1'b1;
    cp0_regs.cause.iv   = 1'b1;
    cp0_regs.status.bev = 1'b1;
    lane_valid          = '0;
    interrupt_req       = 8'h04;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_no_lane", 32'(busy), 32'd0);
    end
    lane_valid = 2'b11;
    set_lane(0, 1'b0, 1'b0, 5'd0, 32'h80000300, 1'b0);
    set_lane(1, 1'b1, 1'b0, EXCCODE_OV, 32'h80000304, 1'b0);
    expect_req(EXCCODE_INT, 32'h80000300, 1'b0, 32'hbfc00400);
    tick();
    pipe_ex            = '0;
    interrupt_req      = '0;
    cp0_regs.status.ie = 1'b0;
    chk("t3_req", 32'(except_req.valid), 32'd1);
    wait_idle("t3_idle");
    cp0_regs.cause.iv   = 1'b0;
    cp0_regs.status.bev = 1'b0;

    // 4: eret with erl, lane exception during flush dropped, cp0 sampled at trigger only
    cp0_regs.status.erl = 1'b1;
    cp0_regs.error_epc  = 32'hbfc00010;
    set_lane(0, 1'b0, 1'b1, 5'd0, 32'h80000400, 1'b0);
    expect_req(5'd0, 32'h80000400, 1'b1, 32'hbfc00010);
    tick();
    pipe_ex = '0;
    set_lane(0, 1'b1, 1'b0, EXCCODE_OV, 32'h80000410, 1'b0);
    cp0_regs.error_epc = 32'h12345678;
    tick();
    pipe_ex = '0;
    wait_idle("t4_idle");
    tick();
    chk("t4_dropped", 32'(sb.size()), 32'd0);
    cp0_regs.status.erl = 1'b0;

    // 5: async reset while redirect is pending
    redirect_ready = 1'b0;
    set_lane(0, 1'b1, 1'b0, EXCCODE_OV, 32'h80000500, 1'b0);
    expect_req(EXCCODE_OV, 32'h80000500, 1'b0, 32'h80000180);
    tick();
    pipe_ex = '0;
    tick();
    tick();
    chk("t5_rv_pre", 32'(redirect_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rv_rst", 32'(redirect_valid), 32'd0);
    chk("t5_flush_rst", 32'(flush), 32'd0);
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_rpc_rst", redirect_pc, 32'd0);
    tick();
    rst            = 1'b0;
    redirect_ready = 1'b1;
    tick();
    chk("t5_after", 32'(busy), 32'd0);

    // 6: TLB refill vector, suppressed by exl
    set_lane(0, 1'b1, 1'b0, EXCCODE_TLBL, 32'h80000600, 1'b1);
    expect_req(EXCCODE_TLBL, 32'h80000600, 1'b0, TLB_VEC);
    tick();
    pipe_ex = '0;
    wait_idle("t6a_idle");
    cp0_regs.status.exl = 1'b1;
    set_lane(0, 1'b1, 1'b0, EXCCODE_TLBS, 32'h80000700, 1'b1);
    expect_req(EXCCODE_TLBS, 32'h80000700, 1'b0, 32'h80000180);
    tick();
    pipe_ex = '0;
    wait_idle("t6b_idle");
    cp0_regs.status.exl = 1'b0;

    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
